// File: rtl/i2s_tx_data_if.sv
// Sample-pair handshake between a stereo sample source and the I2S transmitter.
// The master offers a left/right pair; the slave signals when its buffer can take one.
interface i2s_tx_data_if #(
  parameter int DATA_W = 24
);
  logic [DATA_W-1:0] dataL;
  logic [DATA_W-1:0] dataR;
  logic              tx_valid;
  logic              tx_ready;

  modport master (
    output dataL,
    output dataR,
    output tx_valid,
    input  tx_ready
  );

  modport slave (
    input  dataL,
    input  dataR,
    input  tx_valid,
    output tx_ready
  );
endinterface

// File: rtl/i2s_tx_data.sv
// I2S serial transmitter: follows an external word clock on the bit clock, buffers one
// stereo pair and shifts each word MSB-first with the standard one-bit I2S delay.
module i2s_tx_data #(
  parameter int DATA_W = 24
) (
  input  logic         i2s_bclk,
  input  logic         rst_n,
  input  logic         i2s_wclk,
  i2s_tx_data_if.slave tx,
  output logic         dout,
  output logic         synced,
  output logic         underrun,
  output logic         frame_err
);

  typedef enum logic [0:0] {
    ST_HUNT = 1'b0,
    ST_SYNC = 1'b1
  } state_t;

  localparam logic [4:0] CNT_LAST = 5'(DATA_W - 1);
  localparam logic [4:0] CNT_MAX  = 5'd31;

  state_t            state_r;
  state_t            state_nxt_s;
  logic              synced_s;
  logic              wclk_lat_r;
  logic              boundary_s;
  logic              left_bnd_s;
  logic              right_bnd_s;
  logic              accept_s;
  logic              buf_full_r;
  logic              buf_full_nxt_s;
  logic [DATA_W-1:0] buf_l_r;
  logic [DATA_W-1:0] buf_l_nxt_s;
  logic [DATA_W-1:0] buf_r_r;
  logic [DATA_W-1:0] buf_r_nxt_s;
  logic [DATA_W-1:0] hold_r;
  logic [DATA_W-1:0] hold_nxt_s;
  logic [DATA_W-1:0] shift_r;
  logic [DATA_W-1:0] shift_nxt_s;
  logic [DATA_W-1:0] word_s;
  logic [4:0]        cnt_r;
  logic [4:0]        cnt_nxt_s;
  logic              dout_r;
  logic              dout_nxt_s;
  logic              underrun_r;
  logic              underrun_nxt_s;
  logic              frame_err_r;
  logic              frame_err_nxt_s;

  assign boundary_s  = i2s_wclk ^ wclk_lat_r;
  assign left_bnd_s  = boundary_s & ~i2s_wclk;
  assign right_bnd_s = boundary_s & i2s_wclk;
  assign tx.tx_ready = rst_n & ~buf_full_r;
  assign accept_s    = tx.tx_valid & tx.tx_ready;

  assign dout      = dout_r;
  assign synced    = synced_s;
  assign underrun  = underrun_r;
  assign frame_err = frame_err_r;

  // Alignment state register.
  always_ff @(posedge i2s_bclk) begin
    if (!rst_n) begin
      state_r <= ST_HUNT;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Alignment next state: lock on the first left-channel boundary.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_HUNT: begin
        if (left_bnd_s) begin
          state_nxt_s = ST_SYNC;
        end else begin
          state_nxt_s = ST_HUNT;
        end
      end
      ST_SYNC: state_nxt_s = ST_SYNC;
      default: state_nxt_s = ST_HUNT;
    endcase
  end

  // Alignment outputs.
  always_comb begin
    synced_s = 1'b0;
    case (state_r)
      ST_SYNC: synced_s = 1'b1;
      default: synced_s = 1'b0;
    endcase
  end

  // One-entry pair buffer; a left boundary consumes what was held at the start of the cycle.
  always_comb begin
    buf_full_nxt_s = buf_full_r;
    buf_l_nxt_s    = buf_l_r;
    buf_r_nxt_s    = buf_r_r;
    if (accept_s) begin
      buf_full_nxt_s = 1'b1;
      buf_l_nxt_s    = tx.dataL;
      buf_r_nxt_s    = tx.dataR;
    end else if (left_bnd_s && buf_full_r) begin
      buf_full_nxt_s = 1'b0;
    end else begin
      buf_full_nxt_s = buf_full_r;
    end
  end

  // Word selection at channel boundaries.
  always_comb begin
    word_s         = '0;
    hold_nxt_s     = hold_r;
    underrun_nxt_s = 1'b0;
    if (left_bnd_s) begin
      if (buf_full_r) begin
        word_s     = buf_l_r;
        hold_nxt_s = buf_r_r;
      end else begin
        word_s         = '0;
        hold_nxt_s     = '0;
        underrun_nxt_s = 1'b1;
      end
    end else if (right_bnd_s) begin
      if (synced_s) begin
        word_s = hold_r;
      end else begin
        word_s = '0;
      end
    end else begin
      word_s = '0;
    end
  end

  // Serializer: MSB goes out on the detecting edge, zero fill after the LSB.
  always_comb begin
    shift_nxt_s     = shift_r;
    dout_nxt_s      = 1'b0;
    cnt_nxt_s       = cnt_r;
    frame_err_nxt_s = 1'b0;
    if (boundary_s) begin
      shift_nxt_s     = word_s;
      dout_nxt_s      = word_s[DATA_W-1];
      cnt_nxt_s       = 5'd0;
      frame_err_nxt_s = synced_s & (cnt_r < CNT_LAST);
    end else begin
      shift_nxt_s = {shift_r[DATA_W-2:0], 1'b0};
      dout_nxt_s  = shift_r[DATA_W-2];
      if (cnt_r == CNT_MAX) begin
        cnt_nxt_s = CNT_MAX;
      end else begin
        cnt_nxt_s = cnt_r + 5'd1;
      end
    end
  end

  // Datapath registers; the word-clock latch tracks the pin during reset to avoid a false edge.
  always_ff @(posedge i2s_bclk) begin
    if (!rst_n) begin
      wclk_lat_r  <= i2s_wclk;
      buf_full_r  <= 1'b0;
      buf_l_r     <= '0;
      buf_r_r     <= '0;
      hold_r      <= '0;
      shift_r     <= '0;
      cnt_r       <= CNT_MAX;
      dout_r      <= 1'b0;
      underrun_r  <= 1'b0;
      frame_err_r <= 1'b0;
    end else begin
      wclk_lat_r  <= i2s_wclk;
      buf_full_r  <= buf_full_nxt_s;
      buf_l_r     <= buf_l_nxt_s;
      buf_r_r     <= buf_r_nxt_s;
      hold_r      <= hold_nxt_s;
      shift_r     <= shift_nxt_s;
      cnt_r       <= cnt_nxt_s;
      dout_r      <= dout_nxt_s;
      underrun_r  <= underrun_nxt_s;
      frame_err_r <= frame_err_nxt_s;
    end
  end

endmodule

// File: tb/tb_i2s_tx_data.sv
// Directed bench for i2s_tx_data: the bench drives the word clock, feeds pairs from a queue
// and deserialises dout per half-frame to compare against hand-computed bit patterns.
module tb_i2s_tx_data;

  localparam int DATA_W = 24;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
  } pair_t;

  typedef struct {
    logic [23:0] l;
    logic [23:0] r;
    logic [31:0] exp_l;
    logic [31:0] exp_r;
  } vec_t;

  logic bclk;
  logic rst_n;
  logic wclk;
  logic dout;
  logic synced;
  logic underrun;
  logic frame_err;

  i2s_tx_data_if #(.DATA_W(DATA_W)) tx_if ();

  i2s_tx_data #(.DATA_W(DATA_W)) dut (
    .i2s_bclk  (bclk),
    .rst_n     (rst_n),
    .i2s_wclk  (wclk),
    .tx        (tx_if),
    .dout      (dout),
    .synced    (synced),
    .underrun  (underrun),
    .frame_err (frame_err)
  );

  initial bclk = 1'b0;
  always #5 bclk = ~bclk;

  int    n_tests = 0;
  int    n_fail  = 0;
  pair_t txq[$];
  int    rd_idx;
  int    acc_cnt;

  logic [31:0] cap;
  logic        ur0, fe0, sync0, rdy0;
  int          ur_cnt, fe_cnt, sync_hi;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Pair source: offers the next queued pair, counts handshakes.
  initial begin
    logic take;
    tx_if.tx_valid = 1'b0;
    tx_if.dataL    = '0;
    tx_if.dataR    = '0;
    rd_idx         = 0;
    acc_cnt        = 0;
    forever begin
      @(negedge bclk);
      if (rd_idx < txq.size()) begin
        tx_if.dataL    = txq[rd_idx].l;
        tx_if.dataR    = txq[rd_idx].r;
        tx_if.tx_valid = 1'b1;
      end else begin
        tx_if.tx_valid = 1'b0;
      end
      #2;
      take = tx_if.tx_valid && tx_if.tx_ready;
      @(posedge bclk);
      if (take) begin
        rd_idx++;
        acc_cnt++;
      end
    end
  end

  // Drive the word clock to lvl for len bit clocks and capture dout, MSB of cap first.
  task automatic half(input logic lvl, input int len);
    @(negedge bclk);
    wclk    = lvl;
    cap     = '0;
    ur_cnt  = 0;
    fe_cnt  = 0;
    sync_hi = 0;
    for (int k = 0; k < len; k++) begin
      @(posedge bclk);
      #1;
      if (k < 32) cap[31-k] = dout;
      ur_cnt  += int'(underrun);
      fe_cnt  += int'(frame_err);
      sync_hi += int'(synced);
      if (k == 0) begin
        ur0   = underrun;
        fe0   = frame_err;
        sync0 = synced;
        rdy0  = tx_if.tx_ready;
      end
    end
  endtask

  vec_t        vecs[8];
  logic [23:0] rl[16];
  logic [23:0] rr[16];

  initial begin
    int a0;
    vecs[0] = '{24'h123456, 24'hABCDEF, 32'h12345600, 32'hABCDEF00};
    vecs[1] = '{24'hFFFFFF, 24'h000000, 32'hFFFFFF00, 32'h00000000};
    vecs[2] = '{24'h000001, 24'h800000, 32'h00000100, 32'h80000000};
    vecs[3] = '{24'hA5A5A5, 24'h5A5A5A, 32'hA5A5A500, 32'h5A5A5A00};
    vecs[4] = '{24'h7FFFFF, 24'h800001, 32'h7FFFFF00, 32'h80000100};
    vecs[5] = '{24'h0F0F0F, 24'hF0F0F0, 32'h0F0F0F00, 32'hF0F0F000};
    vecs[6] = '{24'hC00003, 24'h3FFFFC, 32'hC0000300, 32'h3FFFFC00};
    vecs[7] = '{24'h555555, 24'hAAAAAA, 32'h55555500, 32'hAAAAAA00};

    // Reset with word clock low.
    rst_n = 1'b0;
    wclk  = 1'b0;
    repeat (3) @(posedge bclk);
    #1;
    chk("rst_dout", 32'(dout), 32'd0);
    chk("rst_synced", 32'(synced), 32'd0);
    chk("rst_underrun", 32'(underrun), 32'd0);
    chk("rst_frame_err", 32'(frame_err), 32'd0);
    chk("rst_tx_ready", 32'(tx_if.tx_ready), 32'd0);
    @(negedge bclk);
    rst_n = 1'b1;
    #1;
    chk("ready_after_rst", 32'(tx_if.tx_ready), 32'd1);

    // Idle frames before and after alignment.
    half(1'b0, 10);
    chk("pre_sync_dout", cap, 32'd0);
    chk("pre_sync_synced", 32'(sync_hi), 32'd0);
    half(1'b1, 32);
    chk("right_unsync_dout", cap, 32'd0);
    chk("right_unsync_synced", 32'(sync_hi), 32'd0);
    chk("right_unsync_underrun", 32'(ur_cnt), 32'd0);
    half(1'b0, 32);
    chk("first_fall_synced", 32'(sync0), 32'd1);
    chk("first_fall_frame_err", 32'(fe0), 32'd0);
    half(1'b1, 32);
    half(1'b0, 32);
    chk("idle_underrun_pulse", 32'(ur0), 32'd1);
    chk("idle_underrun_count", 32'(ur_cnt), 32'd1);
    chk("idle_dout", cap, 32'd0);
    chk("idle_ready", 32'(rdy0), 32'd1);

    // Extreme-bit pair loaded before a fall.
    txq.push_back('{24'h800001, 24'h7FFFFE});
    half(1'b1, 32);
    half(1'b0, 32);
    chk("pair1_left_bits", cap, 32'h80000100);
    chk("pair1_left_underrun", 32'(ur0), 32'd0);
    chk("pair1_ready_at_fall", 32'(rdy0), 32'd1);
    half(1'b1, 32);
    chk("pair1_right_bits", cap, 32'h7FFFFE00);

    // Back-to-back pairs with tx_valid held high.
    for (int i = 0; i < 8; i++) txq.push_back('{vecs[i].l, vecs[i].r});
    half(1'b1, 8);
    for (int i = 0; i < 8; i++) begin
      a0 = acc_cnt;
      half(1'b0, 32);
      chk($sformatf("vec%0d_left", i), cap, vecs[i].exp_l);
      chk($sformatf("vec%0d_underrun", i), 32'(ur_cnt), 32'd0);
      half(1'b1, 32);
      chk($sformatf("vec%0d_right", i), cap, vecs[i].exp_r);
      chk($sformatf("vec%0d_accepts", i), 32'(acc_cnt - a0), (i < 7) ? 32'd1 : 32'd0);
    end

    // Pair offered on the very edge that detects a fall with the buffer empty.
    txq.push_back('{24'h5A5A5A, 24'hC3C3C3});
    half(1'b0, 32);
    chk("same_edge_underrun", 32'(ur0), 32'd1);
    chk("same_edge_left_zero", cap, 32'd0);
    half(1'b1, 32);
    chk("same_edge_right_zero", cap, 32'd0);
    half(1'b0, 32);
    chk("same_edge_next_left", cap, 32'h5A5A5A00);
    chk("same_edge_next_underrun", 32'(ur0), 32'd0);
    half(1'b1, 32);
    chk("same_edge_next_right", cap, 32'hC3C3C300);

    // Shortened half-frames.
    txq.push_back('{24'hF0F0F1, 24'h3C3C3C});
    half(1'b1, 32);
    half(1'b0, 20);
    chk("short_left_bits", cap, 32'hF0F0F000);
    chk("short_left_frame_err", 32'(fe0), 32'd0);
    half(1'b1, 20);
    chk("short_right_frame_err", 32'(fe0), 32'd1);
    chk("short_right_bits", cap, 32'h3C3C3000);
    half(1'b0, 32);
    chk("short_fall_frame_err", 32'(fe0), 32'd1);
    chk("short_fall_underrun", 32'(ur0), 32'd1);
    chk("short_fall_ferr_count", 32'(fe_cnt), 32'd1);

    // Random pairs through the bench deserialiser.
    for (int i = 0; i < 16; i++) begin
      rl[i] = 24'($urandom());
      rr[i] = 24'($urandom());
      txq.push_back('{rl[i], rr[i]});
    end
    half(1'b1, 32);
    for (int i = 0; i < 16; i++) begin
      half(1'b0, 32);
      chk($sformatf("loop%0d_left", i), cap, {rl[i], 8'h00});
      half(1'b1, 32);
      chk($sformatf("loop%0d_right", i), cap, {rr[i], 8'h00});
    end

    // Reset in the middle of an all-ones word.
    txq.push_back('{24'hFFFFFF, 24'hFFFFFF});
    half(1'b1, 8);
    @(negedge bclk);
    wclk = 1'b0;
    repeat (5) @(posedge bclk);
    #1;
    chk("midword_dout", 32'(dout), 32'd1);
    @(negedge bclk);
    rst_n = 1'b0;
    @(posedge bclk);
    #1;
    chk("midrst_dout", 32'(dout), 32'd0);
    chk("midrst_synced", 32'(synced), 32'd0);
    chk("midrst_tx_ready", 32'(tx_if.tx_ready), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/i2s_tx_data.md
Name: i2s_tx_data

Overview:
- I2S serial transmitter; the send-side counterpart of the I2S receive block.
- Runs on the bit clock and follows a word clock generated elsewhere (I2S core). It does not generate clocks.
- Accepts stereo sample pairs over a valid/ready handshake into a one-entry buffer.
- Shifts each word out MSB-first with the standard one-bit I2S delay, and flags underrun and short-frame conditions.

Parameters:
- DATA_W, 24, sample width in bits; legal range 2..32 (half-frame bit counter is 5 bits wide).

Ports:
- i2s_bclk  input  1  bit clock; the only clock; all logic on its rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- i2s_wclk  input  1  word clock; low half-frame = left channel, high half-frame = right channel.
- dataL  input  DATA_W  left sample, two's complement.
- dataR  input  DATA_W  right sample, two's complement.
- tx_valid  input  1  dataL/dataR pair offered.
- tx_ready  output  1  buffer can accept a pair.
- dout  output  1  serial data, registered.
- synced  output  1  transmitter aligned to a left-channel boundary.
- underrun  output  1  one-cycle pulse: left boundary reached with no buffered pair.
- frame_err  output  1  one-cycle pulse: word clock toggled before the current word finished.

Behaviour:
- Reset (rst_n low at a clock edge):
  - dout=0, synced=0, underrun=0, frame_err=0.
  - Buffer empty; shift register and right-hold register cleared; bit counter saturated at 31.
  - wclk_lat loads i2s_wclk during reset, so no spurious edge is seen when reset releases.
  - tx_ready=0 while rst_n is low. Reset mid-frame aborts the word; dout is 0 on the next cycle.
- tx_ready:
  - Combinational: rst_n AND buffer empty.
  - A pair is accepted on an edge where tx_valid and tx_ready are both 1. The buffer becomes full on the next cycle.
- Edge detect: every edge, wclk_lat <= i2s_wclk; boundary = i2s_wclk XOR wclk_lat.
- Left boundary (boundary with i2s_wclk==0):
  - synced <= 1.
  - If the buffer was full at the start of the cycle: shift register <= dataL from buffer; right-hold <= dataR from buffer; buffer -> empty.
  - Otherwise: shift register <= 0, right-hold <= 0, underrun pulses.
  - No bypass: a pair accepted on that same edge is stored in the buffer and is not sent this frame.
- Right boundary (boundary with i2s_wclk==1):
  - Shift register <= right-hold if synced, else 0. Buffer is untouched.
- Before the first left boundary after reset (synced=0):
  - dout stays 0.
  - No buffer consumption and no underrun pulse.
  - Pairs may still be accepted (one only).
- Shifting:
  - On a boundary edge, dout <= MSB of the newly loaded word.
  - On each following non-boundary edge, the shift register shifts left with zero fill and dout <= next bit.
  - After DATA_W bits, dout holds 0 for the rest of the half-frame.
- Latency and alignment:
  - The MSB appears on dout at the edge that detects the boundary.
  - A same-clock receiver therefore samples the MSB one edge later, i.e. on the 2nd rising edge after the wclk change (standard I2S delay).
- Bit counter:
  - Reset to 0 on a boundary; +1 per non-boundary edge; saturates at 31.
- frame_err:
  - Pulses on a boundary when synced=1 and the counter is < DATA_W-1 (fewer than DATA_W bits driven).
  - The new word still loads and the truncated word is dropped.
- Simultaneous events:
  - Acceptance and left-boundary consumption on the same edge: the consumption sees the buffer as it was at the start of the cycle (see No bypass above).
  - underrun and frame_err may pulse together.

Test Plan:
- Reset with wclk low, 32-bclk half-frames, no tx_valid:
  - dout=0, synced=0 until the first wclk fall.
  - underrun pulses at each left boundary thereafter; tx_ready=1.
- Pair L=0x800001, R=0x7FFFFE loaded before a wclk fall:
  - Bits 1,0x22,1 appear from the detect edge, then 8 zeros.
  - At the rise: bits 0,1x22,0, then 8 zeros.
  - Buffer empties at the fall edge.
- Back-to-back pairs offered every frame, with tx_valid held high:
  - tx_ready drops for exactly one pair per frame.
  - No underrun over 8 frames; output words match input order.
- tx_valid asserted on the same edge as a wclk fall with the buffer empty:
  - Pair accepted and underrun pulses.
  - Zeros are sent in that frame and the pair goes out in the next frame.
- Half-frame shortened to 20 bclks with DATA_W=24:
  - frame_err pulses at the early boundary.
  - The next word starts with its MSB at that edge.
- Loopback to the I2S receive block, 16 random pairs:
  - Receiver dataL/dataR equal the transmitted pairs.
  - Assert rst_n low mid-word: dout=0 the next edge, synced=0, tx_ready=0.
